a1csa_vl_ctrl: RTL and testbench
================================

Name: a1csa_vl_ctrl

Overview:
Variable-latency wrapper around the segmented approximate carry-select adder (a1csa).
- Registers operands and forms a speculative sum. Each segment's carry-in is the previous segment's carry-out computed with carry-in 0.
- Detects carry mispredictions exactly.
- On a misprediction, spends one extra cycle producing the exact sum.
- Feeds the recomputing blocks' consumers. It replaces per-bit recomputation with a registered correction cycle.

Parameters:
N, 16, operand/sum width; must be a multiple of SEG.
SEG, 4, segment width; K = N/SEG segments, K >= 2.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
a  input  N  operand A
b  input  N  operand B
cin  input  1  carry-in to segment 0 (always exact)
in_valid  input  1  operand valid
in_ready  output  1  block can accept operands
sum  output  N  result, registered
cout  output  1  carry-out of bit N-1, registered
recov  output  1  result took the correction cycle
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
err_cnt  output  16  saturating recovery count (see Optional Feature)

Behaviour:
- Reset values: state IDLE; sum=0, cout=0, recov=0, out_valid=0, err_cnt=0. Operand registers are cleared.
- Reset in any state, including mid-FIX or with out_valid high, returns to IDLE next edge and discards the pending result.
- Per segment k, with SEG bits each:
  - P_k = AND of (a^b) bits.
  - Cz_k = segment carry-out with carry-in 0.
  - cspec_0 = cin; cspec_k = Cz_{k-1} for k>=1.
- Speculative sum: each segment is added with carry-in cspec_k.
- err = OR over k=1..K-1 of (P_{k-1} & cspec_{k-1}). This detection is exact: err=0 if and only if speculative sum == exact sum.
- Speculative cout = Cz_{K-1} | (P_{K-1} & cspec_{K-1}).
- All arithmetic is unsigned, modulo 2^N; cout is bit N of a+b+cin.
- FSM states: IDLE, EVAL, FIX, DONE.
  - IDLE: in_ready=1. On in_valid, capture a, b, cin and go to EVAL.
  - EVAL: in_ready=0. Evaluate from the captured registers.
    - err=0: load speculative sum/cout, recov=0, go to DONE.
    - err=1: go to FIX.
  - FIX: in_ready=0. Load exact sum/cout (full ripple/behavioural add of the registers), recov=1, go to DONE.
  - DONE: out_valid=1.
    - out_ready=0: hold sum, cout and recov stable.
    - out_ready=1 and in_valid=1: capture new operands, go to EVAL (back-to-back).
    - out_ready=1 and in_valid=0: go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- out_valid = (state==DONE).
- Latency from the accept edge to out_valid high: 2 cycles when no error, 3 cycles when recovering.
- Inputs are ignored outside an accept edge. Operand changes while busy have no effect.

Optional Feature:
Macro A1CSA_ERR_CNT_EN.
- Defined: err_cnt increments by 1 on each EVAL->FIX transition and saturates at 0xFFFF. It is cleared only by rst.
- Undefined: no counter logic; err_cnt is driven constant 0. The port is still present.

Test Plan:
1. N=16, SEG=4. a=0x0001, b=0x0002, cin=0 -> sum=0x0003, cout=0, recov=0; out_valid 2 cycles after accept.
2. a=0x000F, b=0x0001, cin=0 (segment 0 generates; prediction correct) -> sum=0x0010, recov=0, latency 2.
3. a=0x000F, b=0x0000, cin=1 (P_0 & cin) -> EVAL->FIX; sum=0x0010, recov=1, latency 3. A second case: a=0x0FFF, b=0x0001 -> sum=0x1000, recov=1. Another: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, recov=1.
4. Back-pressure: result 0x0003 with out_ready=0 for 5 cycles -> sum, recov and out_valid held; in_ready=0 throughout.
5. Back-to-back: in DONE with out_ready=1 and in_valid=1 (a=0x1234, b=0x1111) -> new accept the same edge; next result 0x2345 two cycles later.
6. rst asserted during FIX -> next cycle IDLE, out_valid=0, sum=0.
   - With A1CSA_ERR_CNT_EN: 3 recovery ops give err_cnt=3, and rst clears it.
   - Without the macro: err_cnt stays 0.

Source files
------------

// File: rtl/a1csa_vl_ctrl_if.sv
// a1csa_vl_ctrl_if: operand/result handshake bundle for the variable-latency adder wrapper.
interface a1csa_vl_ctrl_if #(parameter int N = 16);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         recov;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  err_cnt;
    modport master (
        output a, b, cin, in_valid, out_ready,
        input  in_ready, sum, cout, recov, out_valid, err_cnt
    );
    modport slave (
        input  a, b, cin, in_valid, out_ready,
        output in_ready, sum, cout, recov, out_valid, err_cnt
    );
endinterface

// File: rtl/a1csa_vl_ctrl.sv
// a1csa_vl_ctrl: variable-latency approximate carry-select adder with exact one-cycle recovery.
// Define A1CSA_ERR_CNT_EN to enable the saturating recovery counter on err_cnt.
module a1csa_vl_ctrl #(
    parameter int N   = 16,
    parameter int SEG = 4
) (
    input logic           clk,
    input logic           rst,
    a1csa_vl_ctrl_if.slave bus
);
    localparam int K = N / SEG;
    typedef enum logic [1:0] {IDLE, EVAL, FIX, DONE} state_t;
    state_t       state, state_nx;
    logic [N-1:0] a_r, b_r, sum_r, sum_spec;
    logic         cin_r, cout_r, recov_r, cout_spec, err, accept;
    logic [K-1:0] p, cz, cspec;
    logic [N:0]   exact;
    genvar k;
    // Each segment speculates its carry-in from the previous segment's zero-carry-in carry-out.
    for (k = 0; k < K; k++) begin : g_seg
        logic [SEG:0] z;
        assign z = {1'b0, a_r[k*SEG +: SEG]} + {1'b0, b_r[k*SEG +: SEG]};
        assign cz[k] = z[SEG];
        assign p[k] = &(a_r[k*SEG +: SEG] ^ b_r[k*SEG +: SEG]);
        assign sum_spec[k*SEG +: SEG] = z[SEG-1:0] + {{(SEG-1){1'b0}}, cspec[k]};
        if (k == 0) begin : g_c0
            assign cspec[k] = cin_r;
        end else begin : g_ck
            assign cspec[k] = cz[k-1];
        end
    end
    // A propagating segment fed a carry is the only way a speculated carry goes wrong.
    assign err = |(p[K-2:0] & cspec[K-2:0]);
    assign cout_spec = cz[K-1] | (p[K-1] & cspec[K-1]);
    assign exact = {1'b0, a_r} + {1'b0, b_r} + {{N{1'b0}}, cin_r};
    assign bus.in_ready = (state == IDLE) | (state == DONE & bus.out_ready);
    assign bus.out_valid = state == DONE;
    assign bus.sum = sum_r;
    assign bus.cout = cout_r;
    assign bus.recov = recov_r;
    assign accept = bus.in_valid & bus.in_ready;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = accept ? EVAL : IDLE;
            EVAL: state_nx = err ? FIX : DONE;
            FIX:  state_nx = DONE;
            DONE: state_nx = !bus.out_ready ? DONE : accept ? EVAL : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            cin_r   <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            recov_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_r   <= bus.a;
                b_r   <= bus.b;
                cin_r <= bus.cin;
            end
            if (state == EVAL && !err) begin
                sum_r   <= sum_spec;
                cout_r  <= cout_spec;
                recov_r <= 1'b0;
            end
            if (state == FIX) begin
                sum_r   <= exact[N-1:0];
                cout_r  <= exact[N];
                recov_r <= 1'b1;
            end
        end
    end
`ifdef A1CSA_ERR_CNT_EN
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (state == EVAL && err && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end
    assign bus.err_cnt = cnt;
`else
    assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_a1csa_vl_ctrl.sv
// tb_a1csa_vl_ctrl: directed checks of speculation, recovery, back-pressure, back-to-back and reset.
module tb_a1csa_vl_ctrl;
`ifdef A1CSA_ERR_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    a1csa_vl_ctrl_if #(.N(16)) vif ();
    a1csa_vl_ctrl #(.N(16), .SEG(4)) dut (.clk(clk), .rst(rst), .bus(vif.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic start(input logic [15:0] a, input logic [15:0] b, input logic c);
        vif.a = a;
        vif.b = b;
        vif.cin = c;
        vif.in_valid = 1'b1;
        chk("accept_ready", {31'd0, vif.in_ready}, 1);
        @(posedge clk);
        #1 vif.in_valid = 1'b0;
    endtask
    task automatic wait_result(input string tag, input logic [15:0] es, input logic ec,
                               input logic er, input int el);
        int lat = 1;
        while (!vif.out_valid && lat < 8) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_sum"}, {16'd0, vif.sum}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, vif.cout}, {31'd0, ec});
        chk({tag, "_recov"}, {31'd0, vif.recov}, {31'd0, er});
    endtask
    task automatic consume();
        vif.out_ready = 1'b1;
        @(posedge clk);
        #1 vif.out_ready = 1'b0;
        chk("consumed_idle", {31'd0, vif.out_valid}, 0);
    endtask
    initial begin
        vif.a = '0;
        vif.b = '0;
        vif.cin = 1'b0;
        vif.in_valid = 1'b0;
        vif.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", {16'd0, vif.sum}, 0);
        chk("rst_cout", {31'd0, vif.cout}, 0);
        chk("rst_recov", {31'd0, vif.recov}, 0);
        chk("rst_valid", {31'd0, vif.out_valid}, 0);
        chk("rst_cnt", {16'd0, vif.err_cnt}, 0);
        rst = 1'b0;
        chk("idle_ready", {31'd0, vif.in_ready}, 1);
        start(16'h0001, 16'h0002, 1'b0);
        wait_result("t1", 16'h0003, 1'b0, 1'b0, 2);
        consume();
        start(16'h000F, 16'h0001, 1'b0);
        wait_result("t2", 16'h0010, 1'b0, 1'b0, 2);
        consume();
        start(16'h000F, 16'h0000, 1'b1);
        wait_result("t3a", 16'h0010, 1'b0, 1'b1, 3);
        consume();
        start(16'h0FFF, 16'h0001, 1'b0);
        wait_result("t3b", 16'h1000, 1'b0, 1'b1, 3);
        consume();
        start(16'hFFFF, 16'h0001, 1'b0);
        wait_result("t3c", 16'h0000, 1'b1, 1'b1, 3);
        consume();
        start(16'h8421, 16'h1248, 1'b1);
        wait_result("t3d", 16'h966A, 1'b0, 1'b0, 2);
        consume();
        chk("cnt3", {16'd0, vif.err_cnt}, CNT_EN * 3);
        start(16'h0001, 16'h0002, 1'b0);
        wait_result("bp", 16'h0003, 1'b0, 1'b0, 2);
        vif.a = 16'hFFFF;
        vif.b = 16'hFFFF;
        vif.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_sum", {16'd0, vif.sum}, 32'h3);
            chk("bp_recov", {31'd0, vif.recov}, 0);
            chk("bp_valid", {31'd0, vif.out_valid}, 1);
            chk("bp_ready", {31'd0, vif.in_ready}, 0);
        end
        vif.in_valid = 1'b0;
        consume();
        start(16'h0001, 16'h0002, 1'b0);
        wait_result("b2b0", 16'h0003, 1'b0, 1'b0, 2);
        vif.a = 16'h1234;
        vif.b = 16'h1111;
        vif.cin = 1'b0;
        vif.in_valid = 1'b1;
        vif.out_ready = 1'b1;
        #1 chk("b2b_ready", {31'd0, vif.in_ready}, 1);
        @(posedge clk);
        #1 vif.in_valid = 1'b0;
        vif.out_ready = 1'b0;
        chk("b2b_eval", {31'd0, vif.out_valid}, 0);
        wait_result("b2b1", 16'h2345, 1'b0, 1'b0, 2);
        consume();
        start(16'h000F, 16'h0000, 1'b1);
        @(posedge clk);
        #1 chk("fix_valid", {31'd0, vif.out_valid}, 0);
        chk("cnt4", {16'd0, vif.err_cnt}, CNT_EN * 4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rfix_valid", {31'd0, vif.out_valid}, 0);
        chk("rfix_sum", {16'd0, vif.sum}, 0);
        chk("rfix_ready", {31'd0, vif.in_ready}, 1);
        chk("rfix_cnt", {16'd0, vif.err_cnt}, 0);
        @(posedge clk);
        #1 chk("rfix_stay", {31'd0, vif.out_valid}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
